vec_wb_collect: RTL and testbench
=================================

Name: vec_wb_collect

Overview:
- Write-back collector that sits directly downstream of the vector ALU lanes.
- Each cycle it captures lane result slices (lane data plus bit offset) into a VLEN-wide destination buffer. It tracks written bytes and applies tail handling from vl/vsew.
- Once all lanes report done, it issues a single byte-enabled write to the vector register file over a valid/ready handshake.

Parameters:
- VLEN, 128, vector register width in bits; multiple of 64, max 512.
- LANE_WIDTH, 4, log2 of bits per lane slice (LANE_BITS = 1<<LANE_WIDTH, 8..64).
- NB_LANES, 2, number of physical lanes feeding the collector (1..8).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse: begin a new instruction; accepted only in IDLE.
- vd_addr  in  5  destination register number, latched on accepted start.
- vl  in  10  active element count, latched on start.
- vsew  in  3  element width code (000=8 .. 011=64), latched on start.
- lane_valid  in  NB_LANES  per-lane slice-valid strobe.
- lane_data  in  NB_LANES*64  per-lane result; only the low LANE_BITS bits are used.
- lane_index  in  NB_LANES*10  per-lane bit offset of the slice inside vd.
- lanes_done  in  1  all lanes finished; level or pulse.
- wb_valid  out  1  write request to the register file.
- wb_ready  in  1  register file accepts the write.
- wb_addr  out  5  destination register.
- wb_data  out  VLEN  assembled register value.
- wb_be  out  VLEN/8  byte enables.
- busy  out  1  high in COLLECT and WRITE.
- err_collide  out  1  sticky: two lanes hit the same byte in one cycle; cleared on accepted start.

Behaviour:
- Reset (async, immediate): state=IDLE; buffer, byte-written mask, latched fields cleared; wb_valid=0, wb_addr=0, wb_data=0, wb_be=0, busy=0, err_collide=0. Reset mid-operation abandons the instruction; no write is issued.
- FSM states: IDLE, COLLECT, WRITE.
- IDLE -> COLLECT on start. Latch vd_addr, vl, vsew; clear buffer and mask; clear err_collide.
- COLLECT:
  - For each lane with lane_valid=1 and lane_index+LANE_BITS <= VLEN: write lane_data[LANE_BITS-1:0] into buffer[lane_index +: LANE_BITS] and set the covered mask bytes.
  - Ignore a slice if lane_index is out of range or not a multiple of LANE_BITS.
  - Lanes are written in index order; on overlap the higher lane number wins and err_collide is set.
  - lanes_done=1 -> WRITE next cycle. Slices valid in the same cycle as lanes_done are captured.
- Tail: byte b is a tail byte when (b*8) >> (vsew+3) >= vl. vsew codes 1xx are treated as vl=0, so every byte is tail.
- Entering WRITE (registered; first WRITE cycle):
  - wb_valid=1, wb_addr=vd_addr, wb_data=buffer.
  - wb_be = mask AND NOT tail (without the optional feature).
- WRITE:
  - wb_valid, wb_addr, wb_data and wb_be hold stable until wb_valid & wb_ready.
  - On that handshake: wb_valid=0 and state -> IDLE in the next cycle.
  - wb_ready is ignored while wb_valid=0.
- Latency: lanes_done at cycle N -> wb_valid at cycle N+1. Zero-wait handshake -> IDLE at N+2.
- start outside IDLE is ignored, including start coinciding with the handshake cycle.
- lane_valid outside COLLECT is ignored.
- vl=0: every byte is tail, so wb_be=0. The write is still issued (handshake completes the instruction).
- busy = (state != IDLE).

Optional Feature:
- Macro VEC_WB_TAIL_AGNOSTIC_EN.
- Defined: tail bytes are driven 0xFF in wb_data with wb_be=1 (tail-agnostic all-ones). Non-tail bytes follow the normal mask.
- Undefined: tail bytes keep wb_be=0, leaving the register-file contents undisturbed. wb_data tail bytes then carry whatever buffer holds (0 if never written).

Test Plan:
1. VLEN=128, LANE_WIDTH=4, NB_LANES=2, vsew=001, vl=8. Lanes deliver 16-bit slices 0x1111..0x8888 at offsets 0,16,..,112 over 4 cycles, then lanes_done=1 -> one cycle later wb_valid=1, wb_data=0x8888777766665555444433332222_1111, wb_be=0xFFFF.
2. Same as 1 but vl=5 -> wb_be=0x03FF. Define VEC_WB_TAIL_AGNOSTIC_EN -> wb_be=0xFFFF and wb_data[127:80] all ones.
3. wb_ready held 0 for 5 cycles after wb_valid -> wb_valid, wb_data and wb_be stable all 5 cycles; wb_ready=1 -> IDLE next cycle, busy=0. A start pulse during the stall is ignored.
4. Both lanes valid with lane_index=32 (lane0 0xAAAA, lane1 0x5555) -> buffer[47:32]=0x5555, err_collide=1; the next accepted start clears it.
5. Assert reset in COLLECT after 2 slices -> immediately busy=0, wb_valid=0. Release reset, then a new start with vl=0 and lanes_done -> wb_valid with wb_be=0, wb_data=0.
6. Final slice with lane_index=112 in the same cycle as lanes_done -> captured, wb_data[127:112] correct. lane_index=128 is ignored: no mask bit set, no error.

Source files
------------

// File: rtl/vec_wb_collect.sv
// Vector write-back collector: assembles lane result slices into a VLEN-bit buffer
// and issues one byte-enabled register-file write. Optional macro: VEC_WB_TAIL_AGNOSTIC_EN.
module vec_wb_collect #(
  parameter int VLEN       = 128,
  parameter int LANE_WIDTH = 4,
  parameter int NB_LANES   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [4:0]             vd_addr,
  input  logic [9:0]             vl,
  input  logic [2:0]             vsew,
  input  logic [NB_LANES-1:0]    lane_valid,
  input  logic [NB_LANES*64-1:0] lane_data,
  input  logic [NB_LANES*10-1:0] lane_index,
  input  logic                   lanes_done,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [4:0]             wb_addr,
  output logic [VLEN-1:0]        wb_data,
  output logic [VLEN/8-1:0]      wb_be,
  output logic                   busy,
  output logic                   err_collide
);

  localparam int LANE_BITS  = 1 << LANE_WIDTH;
  localparam int LANE_BYTES = LANE_BITS / 8;
  localparam int NBYTES     = VLEN / 8;
  localparam int NSLOTS     = VLEN / LANE_BITS;

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_e;

  state_e              state_q, state_d;
  logic [4:0]          vd_q, vd_d;
  logic [9:0]          vl_q, vl_d;
  logic [2:0]          vsew_q, vsew_d;
  logic [VLEN-1:0]     buf_q, buf_d;
  logic [NBYTES-1:0]   mask_q, mask_d;
  logic                err_q, err_d;
  logic                wb_valid_q, wb_valid_d;
  logic [4:0]          wb_addr_q, wb_addr_d;
  logic [VLEN-1:0]     wb_data_q, wb_data_d;
  logic [NBYTES-1:0]   wb_be_q, wb_be_d;
  logic [NBYTES-1:0]   tail;
  logic                slot_hit;
  logic                unused_lane_bits;

  assign unused_lane_bits = ^lane_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = COLLECT;
      COLLECT: if (lanes_done) state_d = WRITE;
      WRITE:   if (wb_valid_q && wb_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != IDLE);
    wb_valid    = wb_valid_q;
    wb_addr     = wb_addr_q;
    wb_data     = wb_data_q;
    wb_be       = wb_be_q;
    err_collide = err_q;
  end

  // Element index of byte b is b >> vsew; reserved widths (1xx) make every byte tail.
  always_comb begin
    tail = '0;
    for (int b = 0; b < NBYTES; b++) begin
      tail[b] = vsew_q[2] | ((10'(b) >> vsew_q[1:0]) >= vl_q);
    end
  end

  always_comb begin
    vd_d       = vd_q;
    vl_d       = vl_q;
    vsew_d     = vsew_q;
    buf_d      = buf_q;
    mask_d     = mask_q;
    err_d      = err_q;
    wb_valid_d = wb_valid_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    wb_be_d    = wb_be_q;
    slot_hit   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          vd_d   = vd_addr;
          vl_d   = vl;
          vsew_d = vsew;
          buf_d  = '0;
          mask_d = '0;
          err_d  = 1'b0;
        end
      end
      COLLECT: begin
        // Only aligned in-range offsets match a slot; later lanes overwrite earlier ones.
        for (int s = 0; s < NSLOTS; s++) begin
          slot_hit = 1'b0;
          for (int l = 0; l < NB_LANES; l++) begin
            if (lane_valid[l] && (lane_index[l*10 +: 10] == 10'(s * LANE_BITS))) begin
              if (slot_hit) err_d = 1'b1;
              slot_hit = 1'b1;
              buf_d[s*LANE_BITS +: LANE_BITS] = lane_data[l*64 +: LANE_BITS];
              for (int k = 0; k < LANE_BYTES; k++) mask_d[s*LANE_BYTES + k] = 1'b1;
            end
          end
        end
        if (lanes_done) begin
          wb_valid_d = 1'b1;
          wb_addr_d  = vd_q;
          for (int b = 0; b < NBYTES; b++) begin
`ifdef VEC_WB_TAIL_AGNOSTIC_EN
            if (tail[b]) begin
              wb_data_d[b*8 +: 8] = 8'hFF;
              wb_be_d[b]          = 1'b1;
            end else begin
              wb_data_d[b*8 +: 8] = buf_d[b*8 +: 8];
              wb_be_d[b]          = mask_d[b];
            end
`else
            wb_data_d[b*8 +: 8] = buf_d[b*8 +: 8];
            wb_be_d[b]          = mask_d[b] & ~tail[b];
`endif
          end
        end
      end
      WRITE: begin
        if (wb_valid_q && wb_ready) wb_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vd_q       <= '0;
      vl_q       <= '0;
      vsew_q     <= '0;
      buf_q      <= '0;
      mask_q     <= '0;
      err_q      <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      wb_be_q    <= '0;
    end else begin
      vd_q       <= vd_d;
      vl_q       <= vl_d;
      vsew_q     <= vsew_d;
      buf_q      <= buf_d;
      mask_q     <= mask_d;
      err_q      <= err_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      wb_be_q    <= wb_be_d;
    end
  end

endmodule

// File: tb/tb_vec_wb_collect.sv
// Self-checking bench for vec_wb_collect: byte-level reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_vec_wb_collect;

  localparam int VLEN       = 128;
  localparam int LANE_WIDTH = 4;
  localparam int NB_LANES   = 2;
  localparam int LANE_BITS  = 16;
  localparam int NBYTES     = VLEN / 8;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   start;
  logic [4:0]             vd_addr;
  logic [9:0]             vl;
  logic [2:0]             vsew;
  logic [NB_LANES-1:0]    lane_valid;
  logic [NB_LANES*64-1:0] lane_data;
  logic [NB_LANES*10-1:0] lane_index;
  logic                   lanes_done;
  logic                   wb_valid;
  logic                   wb_ready;
  logic [4:0]             wb_addr;
  logic [VLEN-1:0]        wb_data;
  logic [NBYTES-1:0]      wb_be;
  logic                   busy;
  logic                   err_collide;

  always #5 clk = ~clk;

  vec_wb_collect #(.VLEN(VLEN), .LANE_WIDTH(LANE_WIDTH), .NB_LANES(NB_LANES)) dut (
    .clk(clk), .reset(reset), .start(start), .vd_addr(vd_addr), .vl(vl), .vsew(vsew),
    .lane_valid(lane_valid), .lane_data(lane_data), .lane_index(lane_index),
    .lanes_done(lanes_done), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
    .wb_data(wb_data), .wb_be(wb_be), .busy(busy), .err_collide(err_collide)
  );

  int checks   = 0;
  int failures = 0;
  bit cmp_on   = 1'b0;

  task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: bytes of the destination, per-byte written flags, phase 0/1/2.
  int          m_phase;
  logic [7:0]  m_buf [NBYTES];
  bit          m_wr  [NBYTES];
  int          m_cnt [NBYTES];
  logic [4:0]  m_vd;
  int          m_vl;
  int          m_vsew;
  bit          m_err;
  bit          m_valid;
  logic [4:0]  m_addr;
  logic [127:0] m_data;
  logic [15:0] m_be;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_vd = 0; m_vl = 0; m_vsew = 0; m_err = 0;
      m_valid = 0; m_addr = 0; m_data = '0; m_be = '0;
      for (int b = 0; b < NBYTES; b++) begin m_buf[b] = 8'h00; m_wr[b] = 0; end
    end else begin
      case (m_phase)
        0: if (start) begin
          m_vd = vd_addr; m_vl = int'(vl); m_vsew = int'(vsew); m_err = 0;
          for (int b = 0; b < NBYTES; b++) begin m_buf[b] = 8'h00; m_wr[b] = 0; end
          m_phase = 1;
        end
        1: begin
          for (int b = 0; b < NBYTES; b++) m_cnt[b] = 0;
          for (int l = 0; l < NB_LANES; l++) begin
            int idx;
            idx = int'(lane_index[l*10 +: 10]);
            if (lane_valid[l] && (idx % LANE_BITS == 0) && (idx + LANE_BITS <= VLEN)) begin
              for (int k = 0; k < LANE_BITS / 8; k++) begin
                m_cnt[idx/8 + k]++;
                m_buf[idx/8 + k] = lane_data[l*64 + k*8 +: 8];
                m_wr[idx/8 + k]  = 1;
              end
            end
          end
          for (int b = 0; b < NBYTES; b++) if (m_cnt[b] > 1) m_err = 1;
          if (lanes_done) begin
            for (int b = 0; b < NBYTES; b++) begin
              bit is_tail;
              is_tail = (m_vsew >= 4) || ((b * 8) / (8 << m_vsew) >= m_vl);
`ifdef VEC_WB_TAIL_AGNOSTIC_EN
              m_data[b*8 +: 8] = is_tail ? 8'hFF : m_buf[b];
              m_be[b]          = is_tail ? 1'b1 : m_wr[b];
`else
              m_data[b*8 +: 8] = m_buf[b];
              m_be[b]          = m_wr[b] && !is_tail;
`endif
            end
            m_valid = 1; m_addr = m_vd; m_phase = 2;
          end
        end
        2: if (wb_ready) begin m_valid = 0; m_phase = 0; end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      checkOutput("cyc_wb_valid", 128'(wb_valid), 128'(m_valid));
      checkOutput("cyc_busy", 128'(busy), 128'(m_phase != 0));
      checkOutput("cyc_err", 128'(err_collide), 128'(m_err));
      checkOutput("cyc_wb_addr", 128'(wb_addr), 128'(m_addr));
      checkOutput("cyc_wb_data", wb_data, m_data);
      checkOutput("cyc_wb_be", 128'(wb_be), 128'(m_be));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] lv, input logic [9:0] i0, input logic [63:0] d0,
                               input logic [9:0] i1, input logic [63:0] d1,
                               input logic done, input logic rdy);
    lane_valid = lv;
    lane_index = {i1, i0};
    lane_data  = {d1, d0};
    lanes_done = done;
    wb_ready   = rdy;
  endtask

  task automatic doStart(input logic [4:0] a, input logic [9:0] n, input logic [2:0] w);
    start = 1'b1; vd_addr = a; vl = n; vsew = w;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [63:0] junkHi(input logic [15:0] v);
    return {$urandom, 16'($urandom), v};
  endfunction

  // 16-bit slices 0x1111..0x8888 at offsets 0..112, then lanes_done; leaves the write pending.
  task automatic runFull(input logic [4:0] a, input logic [9:0] n);
    doStart(a, n, 3'b001);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(2'b11, 10'(32*c), junkHi(16'(16'h1111 * (2*c+1))),
                    10'(32*c+16), junkHi(16'(16'h1111 * (2*c+2))), 1'b0, 1'b0);
      tick();
    end
    applyStimulus(2'b00, 10'd0, 64'd0, 10'd0, 64'd0, 1'b1, 1'b0);
    checkOutput("lat_no_early_valid", 128'(wb_valid), 128'd0);
    tick();
    lanes_done = 1'b0;
  endtask

  task automatic handshake();
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
  endtask

  function automatic logic [9:0] randIdx();
    if ($urandom % 8 == 0) return 10'($urandom_range(0, 1023));
    return 10'($urandom_range(0, 9) * 16);
  endfunction

  localparam logic [127:0] FULL_DATA = 128'h8888777766665555444433332222_1111;

  initial begin
    reset = 1'b1; start = 1'b0; vd_addr = '0; vl = '0; vsew = '0;
    applyStimulus(2'b00, 10'd0, 64'd0, 10'd0, 64'd0, 1'b0, 1'b0);
    tick(); tick();
    reset = 1'b0;
    #1;
    checkOutput("rst_busy", 128'(busy), 128'd0);
    checkOutput("rst_wb_valid", 128'(wb_valid), 128'd0);
    checkOutput("rst_wb_data", wb_data, 128'd0);
    checkOutput("rst_wb_be", 128'(wb_be), 128'd0);
    checkOutput("rst_err", 128'(err_collide), 128'd0);
    cmp_on = 1'b1;
    tick();

    // Full register, all body bytes
    runFull(5'd3, 10'd8);
    checkOutput("t1_valid", 128'(wb_valid), 128'd1);
    checkOutput("t1_addr", 128'(wb_addr), 128'd3);
    checkOutput("t1_data", wb_data, FULL_DATA);
    checkOutput("t1_be", 128'(wb_be), 128'hFFFF);
    handshake();
    checkOutput("t1_idle_busy", 128'(busy), 128'd0);

    // Tail from vl=5 at 16-bit elements
    runFull(5'd4, 10'd5);
`ifdef VEC_WB_TAIL_AGNOSTIC_EN
    checkOutput("t2_be", 128'(wb_be), 128'hFFFF);
    checkOutput("t2_tail_ones", 128'(wb_data[127:80]), 128'hFFFF_FFFF_FFFF);
`else
    checkOutput("t2_be", 128'(wb_be), 128'h03FF);
    checkOutput("t2_data", wb_data, FULL_DATA);
`endif
    handshake();

    // Back-pressure with an ignored start during the stall and on the handshake cycle
    runFull(5'd7, 10'd8);
    for (int i = 0; i < 5; i++) begin
      checkOutput("t3_hold_valid", 128'(wb_valid), 128'd1);
      checkOutput("t3_hold_data", wb_data, FULL_DATA);
      checkOutput("t3_hold_be", 128'(wb_be), 128'hFFFF);
      if (i == 2) begin start = 1'b1; vd_addr = 5'd30; vl = 10'd1; vsew = 3'd0; end
      tick();
      start = 1'b0;
    end
    start = 1'b1;
    handshake();
    start = 1'b0;
    checkOutput("t3_idle_busy", 128'(busy), 128'd0);
    checkOutput("t3_idle_valid", 128'(wb_valid), 128'd0);
    tick();
    checkOutput("t3_start_ignored", 128'(busy), 128'd0);

    // Same-slot collision: lane1 wins, sticky error until next start
    doStart(5'd9, 10'd8, 3'b001);
    applyStimulus(2'b11, 10'd32, junkHi(16'hAAAA), 10'd32, junkHi(16'h5555), 1'b0, 1'b0);
    tick();
    applyStimulus(2'b00, 10'd0, 64'd0, 10'd0, 64'd0, 1'b1, 1'b0);
    tick();
    lanes_done = 1'b0;
    checkOutput("t4_slot", 128'(wb_data[47:32]), 128'h5555);
    checkOutput("t4_be", 128'(wb_be), 128'h0030);
    checkOutput("t4_err", 128'(err_collide), 128'd1);
    handshake();
    checkOutput("t4_err_sticky", 128'(err_collide), 128'd1);
    doStart(5'd10, 10'd8, 3'b001);
    checkOutput("t4_err_cleared", 128'(err_collide), 128'd0);
    lanes_done = 1'b1;
    tick();
    lanes_done = 1'b0;
    handshake();

    // Reset mid-collect, then vl=0 write
    doStart(5'd11, 10'd8, 3'b001);
    applyStimulus(2'b11, 10'd0, junkHi(16'h1234), 10'd16, junkHi(16'h5678), 1'b0, 1'b0);
    tick();
    applyStimulus(2'b00, 10'd0, 64'd0, 10'd0, 64'd0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    checkOutput("t5_rst_busy", 128'(busy), 128'd0);
    checkOutput("t5_rst_valid", 128'(wb_valid), 128'd0);
    tick();
    reset = 1'b0;
    tick();
    doStart(5'd12, 10'd0, 3'b000);
    lanes_done = 1'b1;
    tick();
    lanes_done = 1'b0;
    checkOutput("t5_valid", 128'(wb_valid), 128'd1);
`ifdef VEC_WB_TAIL_AGNOSTIC_EN
    checkOutput("t5_be", 128'(wb_be), 128'hFFFF);
`else
    checkOutput("t5_be", 128'(wb_be), 128'd0);
    checkOutput("t5_data", wb_data, 128'd0);
`endif
    handshake();

    // Last slot with lanes_done, plus an out-of-range slice
    doStart(5'd13, 10'd8, 3'b001);
    applyStimulus(2'b11, 10'd112, junkHi(16'hBEEF), 10'd128, junkHi(16'h1234), 1'b1, 1'b0);
    tick();
    applyStimulus(2'b00, 10'd0, 64'd0, 10'd0, 64'd0, 1'b0, 1'b0);
    checkOutput("t6_top", 128'(wb_data[127:112]), 128'hBEEF);
    checkOutput("t6_be", 128'(wb_be), 128'hC000);
    checkOutput("t6_err", 128'(err_collide), 128'd0);
    handshake();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      start   = ($urandom % 8 == 0);
      vd_addr = 5'($urandom);
      vl      = ($urandom % 8 == 0) ? 10'($urandom) : 10'($urandom_range(0, 20));
      vsew    = 3'($urandom);
      applyStimulus(2'($urandom), randIdx(), {$urandom, $urandom}, randIdx(), {$urandom, $urandom},
                    ($urandom % 6 == 0), ($urandom % 2 == 0));
      reset = ($urandom % 150 == 0);
      tick();
    end
    reset = 1'b0; start = 1'b0;
    applyStimulus(2'b00, 10'd0, 64'd0, 10'd0, 64'd0, 1'b0, 1'b0);
    tick(); tick();
    cmp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
